// File: rtl/seg_pipe_adder.sv
// Pipelined segmented ripple-carry adder/subtractor: one SEG_WIDTH slice resolved per stage.
// Optional feature macro SEG_ADD_OVF_EN adds the registered signed-overflow output ovf_out.
module seg_pipe_adder #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             sub_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SEG_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);
  localparam int NUM_SEG = WIDTH / SEG_WIDTH;

  logic               w_adv;
  logic [WIDTH-1:0]   w_a     [NUM_SEG];
  logic [WIDTH-1:0]   w_b     [NUM_SEG];
  logic [WIDTH-1:0]   w_s     [NUM_SEG];
  logic [WIDTH-1:0]   w_snext [NUM_SEG];
  logic               w_c     [NUM_SEG];
  logic               w_v     [NUM_SEG];
  logic [SEG_WIDTH:0] w_seg   [NUM_SEG];

  logic [WIDTH-1:0]   r_a [NUM_SEG];
  logic [WIDTH-1:0]   r_b [NUM_SEG];
  logic [WIDTH-1:0]   r_s [NUM_SEG];
  logic               r_c [NUM_SEG];
  logic [NUM_SEG-1:0] r_v;

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  assign w_adv    = ready_out | ~valid_out;
  assign ready_in = w_adv;

  // Stage k sees the full operand words; only slice k is consumed there, upper
  // slices ride along as skew, and the partial sum accumulates as de-skew.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      if (k == 0) begin
        w_a[k] = a_in;
        w_b[k] = sub_in ? ~b_in : b_in;
        w_c[k] = sub_in | carry_in;
        w_s[k] = '0;
        w_v[k] = valid_in;
      end else begin
        w_a[k] = r_a[k-1];
        w_b[k] = r_b[k-1];
        w_c[k] = r_c[k-1];
        w_s[k] = r_s[k-1];
        w_v[k] = r_v[k-1];
      end
      w_seg[k] = {1'b0, w_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
               + {1'b0, w_b[k][k*SEG_WIDTH +: SEG_WIDTH]}
               + {{SEG_WIDTH{1'b0}}, w_c[k]};
      w_snext[k] = w_s[k];
      w_snext[k][k*SEG_WIDTH +: SEG_WIDTH] = w_seg[k][SEG_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned k = 0; k < NUM_SEG; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_v <= '0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < NUM_SEG; k++) begin
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_s[k] <= w_snext[k];
        r_c[k] <= w_seg[k][SEG_WIDTH];
        r_v[k] <= w_v[k];
      end
    end
  end

  assign valid_out = r_v[NUM_SEG-1];
  assign sum_out   = r_s[NUM_SEG-1];
  assign carry_out = r_c[NUM_SEG-1];

`ifdef SEG_ADD_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Signs of A and B' are taken at the top stage, alongside the MSB slice of the sum.
  assign w_ovf = (w_a[NUM_SEG-1][WIDTH-1] == w_b[NUM_SEG-1][WIDTH-1])
               & (w_seg[NUM_SEG-1][SEG_WIDTH-1] != w_a[NUM_SEG-1][WIDTH-1]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf_out = r_ovf;
`endif

endmodule
